// File: rtl/gg_loader_pkg.sv
// Shared types and constants for the Game Genie code loader.
// Holds the mapper register number, the FSM and mode enums, the packed cheat
// entry layout and the helper that picks the byte for each slot-port write.
package gg_loader_pkg;

    // Mapper register that exposes the Game Genie slot port.
    localparam logic [7:0] REG_GG = 8'd135;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        IDXRST,
        WRITE,
        DONE,
        ERR
    } state_t;

    typedef enum logic {
        PROG,
        CLR
    } mode_t;

    // 32-bit cheat entry as stored in the local buffer.
    typedef struct packed {
        logic [7:0]  cmp;
        logic [7:0]  data;
        logic        long_code;
        logic [14:0] addr;
    } entry_t;

    // Byte order expected by the slot port: compare, data, {long,addr_hi}, addr_lo.
    function automatic logic [7:0] entry_byte(input entry_t e, input logic [1:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (b)
            2'd0:    r = e.cmp;
            2'd1:    r = e.data;
            2'd2:    r = {e.long_code, e.addr[14:8]};
            default: r = e.addr[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gg_entry_buf.sv
// Cheat entry buffer: SLOTS x 32-bit register file with a fill counter.
// Entries are appended while the loader is idle and never overwritten once
// full; the read port is registered, so rd_entry reflects rd_idx of the
// previous cycle.
module gg_entry_buf
    import gg_loader_pkg::*;
#(
    parameter int SLOTS = 5,
    parameter int CNT_W = 3,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  entry_t           wr_entry,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output entry_t           rd_entry,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [SLOTS];
    entry_t           rd_data_reg;
    logic [CNT_W-1:0] count_reg;
    logic             wr_en;

    assign in_ready = accept_en && (count_reg < CNT_W'(SLOTS));
    assign wr_en    = in_valid && in_ready;
    assign count    = count_reg;
    assign rd_entry = rd_data_reg;

    // Fill counter: grows on each accepted entry, emptied by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
        end else if (wr_en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            // Each slot captures the incoming entry when it is the next free one.
            always_ff @(posedge clk) begin
                if (wr_en && (count_reg == CNT_W'(gi))) begin
                    mem[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    // Registered read of the entry currently being programmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/gg_code_loader.sv
// Game Genie code loader: buffers up to SLOTS cheat entries from the host and,
// on commit, programs them through the mapper cmd_addr/cmd_data port pair:
// select REG_GG, read the data port to reset the slot index, then write four
// bytes per entry. A clear (or empty commit) stops after the index reset,
// which disables every slot.
// Optional bus timeout is enabled by defining GG_LOADER_TIMEOUT_EN.
module gg_code_loader
    import gg_loader_pkg::*;
#(
    parameter int SLOTS   = 5,
    parameter int TMO_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_cmp,
    input  logic        in_long,
    input  logic        commit,
    input  logic        clear,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_sel,
    output logic        bus_rw,
    output logic [7:0]  bus_dout,
    input  logic        bus_ack
);

    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t           state_reg, state_next;
    mode_t            mode_reg, mode_next;
    logic [IDX_W-1:0] e_reg, e_next;
    logic [1:0]       b_reg, b_next;
    logic             bus_req_reg, bus_req_next;
    logic             bus_sel_reg, bus_sel_next;
    logic             bus_rw_reg, bus_rw_next;
    logic [7:0]       bus_dout_reg, bus_dout_next;
    logic             buf_flush;
    entry_t           wr_entry;
    entry_t           rd_entry;
    logic [CNT_W-1:0] count;
    logic             tmo_hit;

    assign wr_entry = '{cmp: in_cmp, data: in_data, long_code: in_long, addr: in_addr};

    // The read index follows e_next so the registered read already holds
    // entry e_reg by the time a write request is issued for it.
    gg_entry_buf #(
        .SLOTS (SLOTS),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .accept_en (state_reg == IDLE),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_entry  (wr_entry),
        .flush     (buf_flush),
        .rd_idx    (e_next),
        .rd_entry  (rd_entry),
        .count     (count)
    );

`ifdef GG_LOADER_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TMO_CYC + 1) > 12) ? $clog2(TMO_CYC + 1) : 12;
    logic [TMO_W-1:0] tmo_cnt_reg;

    // Ack watchdog: restarts when a request is raised, counts while it is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (bus_req_next && !bus_req_reg) begin
            tmo_cnt_reg <= '0;
        end else if (bus_req_reg) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    assign tmo_hit = bus_req_reg && (tmo_cnt_reg == TMO_W'(TMO_CYC - 1));
    assign err     = (state_reg == ERR);
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // State and bus-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mode_reg     <= PROG;
            e_reg        <= '0;
            b_reg        <= '0;
            bus_req_reg  <= 1'b0;
            bus_sel_reg  <= 1'b0;
            bus_rw_reg   <= 1'b1;
            bus_dout_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            e_reg        <= e_next;
            b_reg        <= b_next;
            bus_req_reg  <= bus_req_next;
            bus_sel_reg  <= bus_sel_next;
            bus_rw_reg   <= bus_rw_next;
            bus_dout_reg <= bus_dout_next;
        end
    end

    // Sequencer: each bus state raises one request the cycle after entry (or
    // after the previous ack), then advances when that request is acknowledged.
    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        e_next        = e_reg;
        b_next        = b_reg;
        bus_req_next  = bus_req_reg;
        bus_sel_next  = bus_sel_reg;
        bus_rw_next   = bus_rw_reg;
        bus_dout_next = bus_dout_reg;
        buf_flush     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next = SELECT;
                    mode_next  = CLR;
                end else if (commit) begin
                    state_next = SELECT;
                    mode_next  = PROG;
                end
            end
            SELECT: begin
                if (!bus_req_reg) begin
                    bus_req_next  = 1'b1;
                    bus_sel_next  = 1'b0;
                    bus_rw_next   = 1'b0;
                    bus_dout_next = REG_GG;
                end else if (bus_ack) begin
                    bus_req_next = 1'b0;
                    state_next   = IDXRST;
                end
            end
            IDXRST: begin
                if (!bus_req_reg) begin
                    bus_req_next = 1'b1;
                    bus_sel_next = 1'b1;
                    bus_rw_next  = 1'b1;
                end else if (bus_ack) begin
                    bus_req_next = 1'b0;
                    if (mode_reg == CLR || count == '0) begin
                        state_next = DONE;
                        buf_flush  = (mode_reg == CLR);
                    end else begin
                        state_next = WRITE;
                        e_next     = '0;
                        b_next     = '0;
                    end
                end
            end
            WRITE: begin
                if (!bus_req_reg) begin
                    bus_req_next  = 1'b1;
                    bus_sel_next  = 1'b1;
                    bus_rw_next   = 1'b0;
                    bus_dout_next = entry_byte(rd_entry, b_reg);
                end else if (bus_ack) begin
                    bus_req_next = 1'b0;
                    if (b_reg == 2'd3) begin
                        if (CNT_W'(e_reg) + CNT_W'(1) == count) begin
                            state_next = DONE;
                        end else begin
                            e_next = e_reg + IDX_W'(1);
                            b_next = 2'd0;
                        end
                    end else begin
                        b_next = b_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abandon the pending transaction when the watchdog expires.
        if (tmo_hit && !bus_ack) begin
            bus_req_next = 1'b0;
            state_next   = ERR;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign bus_req  = bus_req_reg;
    assign bus_sel  = bus_sel_reg;
    assign bus_rw   = bus_rw_reg;
    assign bus_dout = bus_dout_reg;

endmodule

// File: tb/tb_gg_code_loader.sv
// Scoreboard bench for gg_code_loader: the stimulus process pushes expected
// bus transactions into a queue; a bus model acknowledges each request after
// a random 1-40 cycle latency and compares it against the queue head.
// Define GG_LOADER_TIMEOUT_EN to also exercise the timeout path (TMO_CYC=16).
module tb_gg_code_loader;

`ifdef GG_LOADER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif
    localparam int SLOTS = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_addr = '0;
    logic [7:0]  in_data = '0;
    logic [7:0]  in_cmp = '0;
    logic        in_long = 1'b0;
    logic        commit = 1'b0;
    logic        clear = 1'b0;
    logic        busy, done, err;
    logic        bus_req, bus_sel, bus_rw;
    logic [7:0]  bus_dout;
    logic        bus_ack = 1'b0;

    always #5 clk = ~clk;

    gg_code_loader #(
        .SLOTS   (SLOTS),
        .TMO_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_cmp   (in_cmp),
        .in_long  (in_long),
        .commit   (commit),
        .clear    (clear),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus_req  (bus_req),
        .bus_sel  (bus_sel),
        .bus_rw   (bus_rw),
        .bus_dout (bus_dout),
        .bus_ack  (bus_ack)
    );

    typedef struct {
        logic       sel;
        logic       rw;
        logic [7:0] dout;
    } txn_t;

    txn_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   acks_seen = 0;
    bit   ack_hold = 1'b0;

    // Reference copy of what the host has pushed.
    logic [14:0] m_addr [SLOTS];
    logic [7:0]  m_data [SLOTS];
    logic [7:0]  m_cmp  [SLOTS];
    logic        m_long [SLOTS];
    int          m_count = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bus model and monitor: acknowledges requests, checks them against the queue.
    initial begin
        forever begin
            txn_t got;
            txn_t exp;
            int   lat;
            @(posedge clk); #1;
            if (bus_req && !ack_hold) begin
                got = '{bus_sel, bus_rw, bus_dout};
                lat = $urandom_range(1, 40);
                repeat (lat - 1) begin
                    @(posedge clk); #1;
                end
                if (bus_req && !ack_hold) begin
                    chk("req_stable", {bus_sel, bus_rw, bus_dout}, {got.sel, got.rw, got.dout});
                    bus_ack = 1'b1;
                    @(posedge clk); #1;
                    bus_ack = 1'b0;
                    acks_seen++;
                    chk("req_drop", {31'd0, bus_req}, 32'd0);
                    if (expq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_txn: got sel=%0d rw=%0d dout=%02h expected none",
                                 got.sel, got.rw, got.dout);
                    end else begin
                        exp = expq.pop_front();
                        chk("txn_sel", {31'd0, got.sel}, {31'd0, exp.sel});
                        chk("txn_rw", {31'd0, got.rw}, {31'd0, exp.rw});
                        if (!exp.rw) chk("txn_dout", {24'd0, got.dout}, {24'd0, exp.dout});
                        $display("txn %0d: sel=%0d rw=%0d dout=%02h lat=%0d",
                                 acks_seen, got.sel, got.rw, got.dout, lat);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic exp_txn(input logic sel, input logic rw, input logic [7:0] dout);
        txn_t t;
        t = '{sel, rw, dout};
        expq.push_back(t);
    endtask

    task automatic exp_hdr();
        exp_txn(1'b0, 1'b0, 8'h87);
        exp_txn(1'b1, 1'b1, 8'h00);
    endtask

    task automatic exp_model();
        for (int i = 0; i < m_count; i++) begin
            exp_txn(1'b1, 1'b0, m_cmp[i]);
            exp_txn(1'b1, 1'b0, m_data[i]);
            exp_txn(1'b1, 1'b0, {m_long[i], m_addr[i][14:8]});
            exp_txn(1'b1, 1'b0, m_addr[i][7:0]);
        end
    endtask

    task automatic push(input logic [14:0] a, input logic [7:0] d, input logic [7:0] c, input logic l);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_cmp   = c;
        in_long  = l;
        chk("in_ready", {31'd0, in_ready}, (m_count < SLOTS) ? 32'd1 : 32'd0);
        if (m_count < SLOTS) begin
            m_addr[m_count] = a;
            m_data[m_count] = d;
            m_cmp[m_count]  = c;
            m_long[m_count] = l;
            m_count++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Pulse commit and/or clear, then wait (bounded) for the done pulse.
    task automatic run_seq(input string name, input logic do_commit, input logic do_clear);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        commit = do_commit;
        clear  = do_clear;
        tick();
        commit = 1'b0;
        clear  = 1'b0;
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        while (n < 2500 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                chk({name, "_no_err"}, {31'd0, err}, 32'd0);
                tick();
                n++;
            end
        end
        chk({name, "_done"}, {31'd0, seen}, 32'd1);
        chk({name, "_all_txn"}, expq.size(), 32'd0);
        tick();
        chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
        expq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        int hi;
        bit seen;

        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_bus", {28'd0, bus_req, bus_sel, bus_rw, 1'b0}, 32'd2);
        chk("rst_dout", {24'd0, bus_dout}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single short code.
        push(15'h1234, 8'hA5, 8'h00, 1'b0);
        exp_hdr();
        exp_txn(1, 0, 8'h00); exp_txn(1, 0, 8'hA5); exp_txn(1, 0, 8'h12); exp_txn(1, 0, 8'h34);
        run_seq("t1", 1'b1, 1'b0);

        // Clear empties the buffer.
        exp_hdr();
        run_seq("clr", 1'b0, 1'b1);
        m_count = 0;

        // 2: fill all slots, sixth push refused.
        for (int i = 0; i < SLOTS; i++) begin
            push(15'h0101 * 15'(i + 1) + 15'h4000, 8'h10 + 8'(i), 8'hC0 + 8'(i), 1'(i % 2));
        end
        push(15'h7ABC, 8'hEE, 8'hDD, 1'b1);
        chk("t2_count", m_count, SLOTS);
        exp_hdr();
        exp_model();
        run_seq("t2", 1'b1, 1'b0);

        // 3: long code, then recommit of the retained buffer.
        exp_hdr();
        run_seq("t3_clr", 1'b0, 1'b1);
        m_count = 0;
        push(15'h7FFF, 8'h01, 8'h3C, 1'b1);
        exp_hdr();
        exp_txn(1, 0, 8'h3C); exp_txn(1, 0, 8'h01); exp_txn(1, 0, 8'hFF); exp_txn(1, 0, 8'hFF);
        run_seq("t3", 1'b1, 1'b0);
        exp_hdr();
        exp_txn(1, 0, 8'h3C); exp_txn(1, 0, 8'h01); exp_txn(1, 0, 8'hFF); exp_txn(1, 0, 8'hFF);
        run_seq("t3_re", 1'b1, 1'b0);

        // 4: clear and commit together with two entries -> clear wins.
        push(15'h0055, 8'h66, 8'h77, 1'b0);
        exp_hdr();
        run_seq("t4", 1'b1, 1'b1);
        m_count = 0;
        exp_hdr();
        run_seq("t4_empty", 1'b1, 1'b0);

        // 5: reset during byte 2 of entry 0.
        push(15'h2ABC, 8'h11, 8'h22, 1'b1);
        push(15'h0F0F, 8'h33, 8'h44, 1'b0);
        exp_hdr();
        exp_model();
        base = acks_seen;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n = 0;
        while (n < 500 && acks_seen < base + 4) begin tick(); n++; end
        chk("t5_reach_b2", acks_seen, base + 4);
        ack_hold = 1'b1;
        n = 0;
        while (n < 10 && !bus_req) begin tick(); n++; end
        chk("t5_b2_req", {22'd0, bus_req, bus_sel, bus_rw, bus_dout}, {22'd0, 1'b1, 1'b1, 1'b0, 8'hAA});
        rst = 1'b1;
        tick();
        chk("t5_req", {31'd0, bus_req}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        repeat (45) tick();
        expq.delete();
        m_count = 0;
        ack_hold = 1'b0;
        exp_hdr();
        run_seq("t5_empty", 1'b1, 1'b0);

`ifdef GG_LOADER_TIMEOUT_EN
        // 6: withhold ack in SELECT until the watchdog fires.
        push(15'h0321, 8'h9A, 8'h00, 1'b0);
        ack_hold = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n = 0;
        hi = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            if (err) seen = 1'b1;
            else begin
                if (bus_req) hi++;
                tick();
                n++;
            end
        end
        chk("t6_err", {31'd0, seen}, 32'd1);
        chk("t6_req_cycles", hi, TMO);
        chk("t6_req_low", {31'd0, bus_req}, 32'd0);
        tick();
        chk("t6_err_pulse", {31'd0, err}, 32'd0);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        ack_hold = 1'b0;
        exp_hdr();
        exp_txn(1, 0, 8'h00); exp_txn(1, 0, 8'h9A); exp_txn(1, 0, 8'h03); exp_txn(1, 0, 8'h21);
        run_seq("t6_retained", 1'b1, 1'b0);
`else
        hi = 0;
        seen = 1'b0;
        n = hi + int'(seen);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
